// File: rtl/fsmc_pkg.sv
// fsmc_pkg: shared definitions for the FSMC initiator.
//   - FSMC_AW / FSMC_DW: bus address and data widths
//   - fsmc_state_e:      bus phase encoding (IDLE, SETUP, DATA, TURN)
//   - REG_*:             motor CPLD register map addresses
//   - fsmc_clamp():      forces a timing parameter into its legal 4-bit range
package fsmc_pkg;

    localparam int FSMC_AW = 5;
    localparam int FSMC_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DATA,
        TURN
    } fsmc_state_e;

    // Control / PWM registers
    localparam logic [FSMC_AW-1:0] REG_CTRL12   = 5'd0;
    localparam logic [FSMC_AW-1:0] REG_M1_CNT_L = 5'd1;
    localparam logic [FSMC_AW-1:0] REG_M1_CNT_H = 5'd2;
    localparam logic [FSMC_AW-1:0] REG_M2_CNT_L = 5'd3;
    localparam logic [FSMC_AW-1:0] REG_M2_CNT_H = 5'd4;
    localparam logic [FSMC_AW-1:0] REG_M3_CNT_L = 5'd5;
    localparam logic [FSMC_AW-1:0] REG_M3_CNT_H = 5'd6;
    localparam logic [FSMC_AW-1:0] REG_PWM_DIV  = 5'd7;
    localparam logic [FSMC_AW-1:0] REG_M1_DUTY_L = 5'd8;
    localparam logic [FSMC_AW-1:0] REG_M1_DUTY_H = 5'd9;
    localparam logic [FSMC_AW-1:0] REG_M2_DUTY_L = 5'd10;
    localparam logic [FSMC_AW-1:0] REG_M2_DUTY_H = 5'd11;
    localparam logic [FSMC_AW-1:0] REG_M3_DUTY_L = 5'd12;
    localparam logic [FSMC_AW-1:0] REG_M3_DUTY_H = 5'd13;

    // Status registers
    localparam logic [FSMC_AW-1:0] REG_S_STAT  = 5'd15;
    localparam logic [FSMC_AW-1:0] REG_M1_STAT = 5'd16;
    localparam logic [FSMC_AW-1:0] REG_M2_STAT = 5'd17;
    localparam logic [FSMC_AW-1:0] REG_M3_STAT = 5'd18;

    // Phase lengths live in a 4-bit down-counter, so anything above 15 is
    // saturated; values below the phase minimum are raised to it.
    function automatic logic [3:0] fsmc_clamp(input int value, input int min_value);
        int v;
        v = value;
        if (v < min_value) v = min_value;
        if (v > 15) v = 15;
        return v[3:0];
    endfunction

endpackage

// File: rtl/fsmc_master_if.sv
// fsmc_master_if: request/response handshake plus FSMC bus pins.
//   Request : req_valid, req_ready, req_wr, req_addr, req_wdata
//   Response: rsp_valid, rsp_rdata, busy
//   Bus     : fsmc_a, fsmc_ne1, fsmc_noe, fsmc_nwe, fsmc_d_o, fsmc_d_oe, fsmc_d_i
// modport master is the initiator view, modport slave is the environment
// (requester + responder + pad) view.
interface fsmc_master_if;
    import fsmc_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic               req_wr;
    logic [FSMC_AW-1:0] req_addr;
    logic [FSMC_DW-1:0] req_wdata;
    logic               rsp_valid;
    logic [FSMC_DW-1:0] rsp_rdata;
    logic               busy;
    logic [FSMC_AW-1:0] fsmc_a;
    logic               fsmc_ne1;
    logic               fsmc_noe;
    logic               fsmc_nwe;
    logic [FSMC_DW-1:0] fsmc_d_o;
    logic               fsmc_d_oe;
    logic [FSMC_DW-1:0] fsmc_d_i;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, fsmc_d_i,
        output req_ready, rsp_valid, rsp_rdata, busy,
               fsmc_a, fsmc_ne1, fsmc_noe, fsmc_nwe, fsmc_d_o, fsmc_d_oe
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, fsmc_d_i,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               fsmc_a, fsmc_ne1, fsmc_noe, fsmc_nwe, fsmc_d_o, fsmc_d_oe
    );

endinterface

// File: rtl/fsmc_master.sv
// fsmc_master: initiator for the 5-bit address / 8-bit data FSMC SRAM-style
// bus. Each accepted request runs SETUP (ADDSET cycles, NE1 low, A valid),
// DATA (DATAST cycles, NOE or NWE low) and TURN (BUSTURN cycles, NE1 high)
// and produces one rsp_valid pulse in the first TURN cycle.
// Ports:
//   clk   - system clock (50 MHz)
//   rst_n - asynchronous active-low reset, drops any access in flight
//   bus   - fsmc_master_if.master: request/response handshake and bus pins
// Every output comes straight from a flop; the data pad tristate sits in
// the enclosing top level and is steered by fsmc_d_oe.
module fsmc_master
    import fsmc_pkg::*;
#(
    parameter int ADDSET  = 2,
    parameter int DATAST  = 4,
    parameter int BUSTURN = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fsmc_master_if.master bus
);

    // DATA needs at least two cycles because the responder samples on the
    // falling edge; the other phases just need to exist.
    localparam logic [3:0] SETUP_LEN = fsmc_clamp(ADDSET, 1);
    localparam logic [3:0] DATA_LEN  = fsmc_clamp(DATAST, 2);
    localparam logic [3:0] TURN_LEN  = fsmc_clamp(BUSTURN, 1);

    fsmc_state_e        state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [FSMC_AW-1:0] a_q, a_d;
    logic [FSMC_DW-1:0] d_o_q, d_o_d;
    logic [FSMC_DW-1:0] rdata_q, rdata_d;
    logic               ne1_q, ne1_d;
    logic               noe_q, noe_d;
    logic               nwe_q, nwe_d;
    logic               d_oe_q, d_oe_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    // Next-state logic. Bus pin values are computed for the phase being
    // entered so that the registered pins change on the same edge as the
    // state, with the counter loaded to (phase length - 1) on entry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        a_d         = a_q;
        d_o_d       = d_o_q;
        rdata_d     = rdata_q;
        ne1_d       = ne1_q;
        noe_d       = noe_q;
        nwe_d       = nwe_q;
        d_oe_d      = d_oe_q;
        rsp_valid_d = 1'b0;
        busy_d      = busy_q;
        ready_d     = ready_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LEN - 4'd1;
                    wr_d    = bus.req_wr;
                    a_d     = bus.req_addr;
                    if (bus.req_wr) begin
                        d_o_d = bus.req_wdata;
                    end
                    ne1_d   = 1'b0;
                    d_oe_d  = bus.req_wr;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = DATA;
                    cnt_d   = DATA_LEN - 4'd1;
                    noe_d   = wr_q;
                    nwe_d   = ~wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DATA: begin
                if (cnt_q == 4'd0) begin
                    // Read data is taken on the edge that releases the strobe.
                    state_d     = TURN;
                    cnt_d       = TURN_LEN - 4'd1;
                    ne1_d       = 1'b1;
                    noe_d       = 1'b1;
                    nwe_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (!wr_q) begin
                        rdata_d = bus.fsmc_d_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TURN: begin
                // Write data is held for exactly the first TURN cycle.
                d_oe_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            a_q         <= '0;
            d_o_q       <= '0;
            rdata_q     <= '0;
            ne1_q       <= 1'b1;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
            d_oe_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            a_q         <= a_d;
            d_o_q       <= d_o_d;
            rdata_q     <= rdata_d;
            ne1_q       <= ne1_d;
            noe_q       <= noe_d;
            nwe_q       <= nwe_d;
            d_oe_q      <= d_oe_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.fsmc_a    = a_q;
    assign bus.fsmc_ne1  = ne1_q;
    assign bus.fsmc_noe  = noe_q;
    assign bus.fsmc_nwe  = nwe_q;
    assign bus.fsmc_d_o  = d_o_q;
    assign bus.fsmc_d_oe = d_oe_q;

endmodule

// File: tb/tb_fsmc_master.sv
// tb_fsmc_master: two initiators (default timing and under-range timing)
// sharing one register-file responder; requests go to the bus picked by sel.
module tb_fsmc_master;

    localparam int A_SET  = 2;
    localparam int A_DAT  = 4;
    localparam int A_TRN  = 2;
    localparam int B_RAW_SET = 0;
    localparam int B_RAW_DAT = 1;
    localparam int B_RAW_TRN = 0;
    // The under-range values get raised to the phase minimums 1 / 2 / 1.
    localparam int B_SET = (B_RAW_SET < 1) ? 1 : B_RAW_SET;
    localparam int B_DAT = (B_RAW_DAT < 2) ? 2 : B_RAW_DAT;
    localparam int B_TRN = (B_RAW_TRN < 1) ? 1 : B_RAW_TRN;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic [4:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       sel = 1'b0;
    logic       manual = 1'b0;
    logic [7:0] manual_d = '0;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    fsmc_master_if bus_a();
    fsmc_master_if bus_b();

    fsmc_master #(.ADDSET(A_SET), .DATAST(A_DAT), .BUSTURN(A_TRN)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    fsmc_master #(.ADDSET(B_RAW_SET), .DATAST(B_RAW_DAT), .BUSTURN(B_RAW_TRN)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    logic       o_ready, o_rsp_valid, o_busy, o_ne1, o_noe, o_nwe, o_doe;
    logic [4:0] o_a;
    logic [7:0] o_do, o_rdata, rd_bus;

    assign bus_a.req_valid = req_valid & ~sel;
    assign bus_b.req_valid = req_valid & sel;
    assign bus_a.req_wr    = req_wr;
    assign bus_b.req_wr    = req_wr;
    assign bus_a.req_addr  = req_addr;
    assign bus_b.req_addr  = req_addr;
    assign bus_a.req_wdata = req_wdata;
    assign bus_b.req_wdata = req_wdata;

    assign o_ready     = sel ? bus_b.req_ready : bus_a.req_ready;
    assign o_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign o_busy      = sel ? bus_b.busy      : bus_a.busy;
    assign o_ne1       = sel ? bus_b.fsmc_ne1  : bus_a.fsmc_ne1;
    assign o_noe       = sel ? bus_b.fsmc_noe  : bus_a.fsmc_noe;
    assign o_nwe       = sel ? bus_b.fsmc_nwe  : bus_a.fsmc_nwe;
    assign o_doe       = sel ? bus_b.fsmc_d_oe : bus_a.fsmc_d_oe;
    assign o_a         = sel ? bus_b.fsmc_a    : bus_a.fsmc_a;
    assign o_do        = sel ? bus_b.fsmc_d_o  : bus_a.fsmc_d_o;
    assign o_rdata     = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;

    // Electric_bend responder: register file written on the falling edge
    // while NWE is low, read data driven while NOE is low.
    logic [7:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    end
    always @(negedge clk) begin
        if (o_ne1 === 1'b0 && o_nwe === 1'b0 && o_doe === 1'b1) mem[o_a] <= o_do;
    end
    assign rd_bus = (o_ne1 === 1'b0 && o_noe === 1'b0) ? mem[o_a] : 8'hEE;
    assign bus_a.fsmc_d_i = manual ? manual_d : rd_bus;
    assign bus_b.fsmc_d_i = manual ? manual_d : rd_bus;

    // Reference contents of the register file and last read per initiator.
    logic [7:0] ref_mem [32];
    logic [7:0] last_rd [2];

    // Bus protocol watch on both initiators every cycle.
    always @(negedge clk) begin
        checks += 4;
        if (bus_a.fsmc_noe === 1'b0 && bus_a.fsmc_nwe === 1'b0) begin
            errors++; $display("[TB] FAIL strobe_overlap_a: noe=0 nwe=0, required not both low");
        end
        if (bus_a.fsmc_noe === 1'b0 && bus_a.fsmc_d_oe !== 1'b0) begin
            errors++; $display("[TB] FAIL doe_during_read_a: d_oe=%b with noe=0, required 0", bus_a.fsmc_d_oe);
        end
        if (bus_b.fsmc_noe === 1'b0 && bus_b.fsmc_nwe === 1'b0) begin
            errors++; $display("[TB] FAIL strobe_overlap_b: noe=0 nwe=0, required not both low");
        end
        if (bus_b.fsmc_noe === 1'b0 && bus_b.fsmc_d_oe !== 1'b0) begin
            errors++; $display("[TB] FAIL doe_during_read_b: d_oe=%b with noe=0, required 0", bus_b.fsmc_d_oe);
        end
    end

    logic       rec_ne1 [64];
    logic       rec_noe [64];
    logic       rec_nwe [64];
    logic       rec_doe [64];
    logic [4:0] rec_a   [64];
    logic [7:0] rec_do  [64];

    function automatic int cur_set(); return sel ? B_SET : A_SET; endfunction
    function automatic int cur_dat(); return sel ? B_DAT : A_DAT; endfunction
    function automatic int cur_trn(); return sel ? B_TRN : A_TRN; endfunction

    // One request on the selected bus. Cycle n counts from the first cycle
    // after the accepting edge; pins are recorded per cycle. With junk set,
    // REQ_VALID toggles randomly while the initiator is busy.
    task automatic do_txn(input logic wr, input logic [4:0] addr, input logic [7:0] wdata,
                          input bit junk, input int pulse_n, output logic [7:0] rdata,
                          output int rsp_n, output int rsp_count, output int ready_n);
        rdata = '0; rsp_n = -1; rsp_count = 0; ready_n = -1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL ready_before_req: got %b, required 1", o_ready);
        end
        req_wr = wr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n < 60; n++) begin
            @(negedge clk);
            manual_d = (n == pulse_n) ? 8'h5A : 8'h00;
            rec_ne1[n] = o_ne1; rec_noe[n] = o_noe; rec_nwe[n] = o_nwe;
            rec_doe[n] = o_doe; rec_a[n] = o_a; rec_do[n] = o_do;
            if (o_rsp_valid === 1'b1) begin
                rsp_count++; rsp_n = n; rdata = o_rdata;
            end
            if (o_ready === 1'b1) begin
                ready_n = n; req_valid = 1'b0;
                break;
            end
            if (junk) begin
                req_valid = 1'($urandom_range(0, 1));
                req_wr = 1'($urandom_range(0, 1));
                req_addr = 5'($urandom);
                req_wdata = 8'($urandom);
            end
        end
        manual_d = 8'h00;
        checks++;
        if (ready_n < 0) begin
            errors++; $display("[TB] FAIL txn_timeout: ready not seen within 60 cycles, required by %0d",
                               cur_set() + cur_dat() + cur_trn() + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_a.fsmc_ne1, bus_a.fsmc_noe, bus_a.fsmc_nwe, bus_a.fsmc_d_oe, bus_a.rsp_valid, bus_a.busy} !== 6'b111000) begin
            errors++; $display("[TB] FAIL reset_ctrl_a: ne1/noe/nwe/doe/rsp/busy=%b, required 111000",
                {bus_a.fsmc_ne1, bus_a.fsmc_noe, bus_a.fsmc_nwe, bus_a.fsmc_d_oe, bus_a.rsp_valid, bus_a.busy});
        end
        checks++;
        if ({bus_a.fsmc_a, bus_a.fsmc_d_o, bus_a.rsp_rdata} !== 21'd0) begin
            errors++; $display("[TB] FAIL reset_data_a: a=%h d_o=%h rdata=%h, required 0", bus_a.fsmc_a, bus_a.fsmc_d_o, bus_a.rsp_rdata);
        end
        checks++;
        if ({bus_b.fsmc_ne1, bus_b.fsmc_noe, bus_b.fsmc_nwe, bus_b.fsmc_d_oe, bus_b.rsp_valid, bus_b.busy} !== 6'b111000) begin
            errors++; $display("[TB] FAIL reset_ctrl_b: ne1/noe/nwe/doe/rsp/busy=%b, required 111000",
                {bus_b.fsmc_ne1, bus_b.fsmc_noe, bus_b.fsmc_nwe, bus_b.fsmc_d_oe, bus_b.rsp_valid, bus_b.busy});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_a.req_ready !== 1'b1 || bus_b.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready: a=%b b=%b, required 1 1", bus_a.req_ready, bus_b.req_ready);
        end
    endtask

    task automatic test_write_timing();
        logic [7:0] rd; int rn, rc, yn, s, d, last;
        sel = 1'b0; s = cur_set(); d = cur_dat();
        do_txn(1'b1, 5'd3, 8'hA5, 1'b0, -1, rd, rn, rc, yn);
        ref_mem[3] = 8'hA5;
        last = (yn > 0) ? yn : 10;
        for (int n = 1; n <= last; n++) begin
            checks++;
            if (rec_ne1[n] !== ((n <= s + d) ? 1'b0 : 1'b1)) begin
                errors++; $display("[TB] FAIL wr_ne1 cycle %0d: got %b, required %b", n, rec_ne1[n], (n <= s + d) ? 1'b0 : 1'b1);
            end
            checks++;
            if (rec_nwe[n] !== ((n > s && n <= s + d) ? 1'b0 : 1'b1)) begin
                errors++; $display("[TB] FAIL wr_nwe cycle %0d: got %b, required %b", n, rec_nwe[n], (n > s && n <= s + d) ? 1'b0 : 1'b1);
            end
            checks++;
            if (rec_doe[n] !== ((n <= s + d + 1) ? 1'b1 : 1'b0)) begin
                errors++; $display("[TB] FAIL wr_doe cycle %0d: got %b, required %b", n, rec_doe[n], (n <= s + d + 1) ? 1'b1 : 1'b0);
            end
            checks++;
            if (rec_noe[n] !== 1'b1 || rec_a[n] !== 5'd3 || (rec_doe[n] === 1'b1 && rec_do[n] !== 8'hA5)) begin
                errors++; $display("[TB] FAIL wr_addr_data cycle %0d: noe=%b a=%0d d_o=%h, required 1 3 A5", n, rec_noe[n], rec_a[n], rec_do[n]);
            end
        end
        checks++;
        if (rc !== 1 || rn !== 7) begin
            errors++; $display("[TB] FAIL wr_rsp: count=%0d at=%0d, required 1 at 7", rc, rn);
        end
        checks++;
        if (yn !== 9) begin
            errors++; $display("[TB] FAIL wr_ready: at %0d, required 9", yn);
        end
    endtask

    task automatic test_read_capture();
        logic [7:0] rd; int rn, rc, yn, s, d;
        sel = 1'b0; s = cur_set(); d = cur_dat();
        manual = 1'b1;
        do_txn(1'b0, 5'd16, 8'h00, 1'b0, s + d, rd, rn, rc, yn);
        manual = 1'b0;
        checks++;
        if (rd !== 8'h5A) begin
            errors++; $display("[TB] FAIL rd_capture: got %h, required 5A", rd);
        end
        checks++;
        if (rc !== 1 || rn !== s + d + 1) begin
            errors++; $display("[TB] FAIL rd_rsp: count=%0d at=%0d, required 1 at %0d", rc, rn, s + d + 1);
        end
        for (int n = 1; n <= ((yn > 0) ? yn : 10); n++) begin
            checks++;
            if (rec_doe[n] !== 1'b0 || rec_noe[n] !== ((n > s && n <= s + d) ? 1'b0 : 1'b1)) begin
                errors++; $display("[TB] FAIL rd_pins cycle %0d: doe=%b noe=%b, required 0 %b", n, rec_doe[n], rec_noe[n], (n > s && n <= s + d) ? 1'b0 : 1'b1);
            end
        end
        last_rd[0] = 8'h5A;
    endtask

    task automatic test_back_to_back();
        logic       tw [4];
        logic [4:0] ta [4];
        logic [7:0] td [4];
        int idx, rsp_cnt, high_run, gaps;
        bit accept, seen_low;
        tw[0] = 1'b1; ta[0] = 5'd3; td[0] = 8'h34;
        tw[1] = 1'b1; ta[1] = 5'd4; td[1] = 8'h12;
        tw[2] = 1'b0; ta[2] = 5'd3; td[2] = 8'h00;
        tw[3] = 1'b0; ta[3] = 5'd4; td[3] = 8'h00;
        sel = 1'b0; idx = 0; rsp_cnt = 0; high_run = 0; gaps = 0; seen_low = 1'b0;
        @(negedge clk);
        req_wr = tw[0]; req_addr = ta[0]; req_wdata = td[0]; req_valid = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            accept = (o_ready === 1'b1) && req_valid && (idx < 4);
            @(posedge clk);
            #1;
            if (accept) begin
                idx++;
                if (idx < 4) begin
                    req_wr = tw[idx]; req_addr = ta[idx]; req_wdata = td[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (o_rsp_valid === 1'b1 && rsp_cnt < 4) begin
                if (!tw[rsp_cnt]) begin
                    checks++;
                    if (o_rdata !== ((ta[rsp_cnt] == 5'd3) ? 8'h34 : 8'h12)) begin
                        errors++; $display("[TB] FAIL b2b_read addr %0d: got %h, required %h", ta[rsp_cnt], o_rdata, (ta[rsp_cnt] == 5'd3) ? 8'h34 : 8'h12);
                    end
                end
                rsp_cnt++;
            end
            if (o_ne1 === 1'b1) begin
                high_run++;
            end else begin
                if (seen_low && high_run > 0) begin
                    gaps++;
                    checks++;
                    if (high_run < A_TRN + 1) begin
                        errors++; $display("[TB] FAIL b2b_ne1_gap: high for %0d cycles, required >= %0d", high_run, A_TRN + 1);
                    end
                end
                high_run = 0;
                seen_low = 1'b1;
            end
            if (idx == 4 && rsp_cnt == 4 && o_ready === 1'b1) break;
        end
        req_valid = 1'b0;
        checks++;
        if (idx !== 4 || rsp_cnt !== 4 || gaps !== 3) begin
            errors++; $display("[TB] FAIL b2b_counts: accepted=%0d responses=%0d gaps=%0d, required 4 4 3", idx, rsp_cnt, gaps);
        end
        ref_mem[3] = 8'h34; ref_mem[4] = 8'h12; last_rd[0] = 8'h12;
    endtask

    task automatic test_clamped_timing();
        logic [7:0] rd; int rn, rc, yn, nwe_low, ne1_low;
        sel = 1'b1;
        do_txn(1'b1, 5'd5, 8'h77, 1'b0, -1, rd, rn, rc, yn);
        ref_mem[5] = 8'h77;
        nwe_low = 0; ne1_low = 0;
        for (int n = 1; n <= ((yn > 0) ? yn : 10); n++) begin
            if (rec_nwe[n] === 1'b0) nwe_low++;
            if (rec_ne1[n] === 1'b0) ne1_low++;
        end
        checks++;
        if (nwe_low !== 2 || ne1_low !== 3) begin
            errors++; $display("[TB] FAIL clamp_strobe: nwe low %0d ne1 low %0d, required 2 3", nwe_low, ne1_low);
        end
        checks++;
        if (rn !== 4 || yn !== 5 || rc !== 1) begin
            errors++; $display("[TB] FAIL clamp_timing: rsp at %0d ready at %0d count %0d, required 4 5 1", rn, yn, rc);
        end
        do_txn(1'b0, 5'd5, 8'h00, 1'b0, -1, rd, rn, rc, yn);
        checks++;
        if (rd !== 8'h77 || yn !== 5) begin
            errors++; $display("[TB] FAIL clamp_read: data %h ready at %0d, required 77 5", rd, yn);
        end
        last_rd[1] = 8'h77;
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] rd; int rn, rc, yn;
        sel = 1'b0;
        @(negedge clk);
        req_wr = 1'b1; req_addr = 5'd7; req_wdata = 8'hC3; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (A_SET + 2) @(negedge clk);
        checks++;
        if (o_nwe !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_pre_data: nwe=%b, required 0", o_nwe);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ne1, o_nwe, o_noe, o_doe, o_busy, o_rsp_valid, o_ready} !== 7'b1110001) begin
            errors++; $display("[TB] FAIL rst_immediate: ne1/nwe/noe/doe/busy/rsp/ready=%b, required 1110001",
                {o_ne1, o_nwe, o_noe, o_doe, o_busy, o_rsp_valid, o_ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++;
            if (o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
                errors++; $display("[TB] FAIL rst_dropped cycle %0d: rsp=%b busy=%b, required 0 0", n, o_rsp_valid, o_busy);
            end
        end
        // The write strobe had already been low across two responder
        // sampling edges before reset, so the register holds the new value.
        ref_mem[7] = 8'hC3;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        checks++;
        if (o_rdata !== 8'h00) begin
            errors++; $display("[TB] FAIL rst_rdata: got %h, required 00", o_rdata);
        end
        do_txn(1'b0, 5'd0, 8'h00, 1'b0, -1, rd, rn, rc, yn);
        checks++;
        if (rd !== ref_mem[0] || rc !== 1 || rn !== A_SET + A_DAT + 1 || yn !== A_SET + A_DAT + A_TRN + 1) begin
            errors++; $display("[TB] FAIL rst_post_read: data %h count %0d rsp %0d ready %0d, required %h 1 %0d %0d",
                rd, rc, rn, yn, ref_mem[0], A_SET + A_DAT + 1, A_SET + A_DAT + A_TRN + 1);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, wd; logic [4:0] ad; logic wr; int rn, rc, yn, s, d, b, gap;
        bit junk;
        for (int i = 0; i < 500; i++) begin
            sel = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            ad = 5'($urandom);
            wd = 8'($urandom);
            junk = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 3);
            s = cur_set(); d = cur_dat(); b = cur_trn();
            repeat (gap) @(negedge clk);
            do_txn(wr, ad, wd, junk, -1, rd, rn, rc, yn);
            checks++;
            if (rc !== 1 || rn !== s + d + 1 || yn !== s + d + b + 1) begin
                errors++; $display("[TB] FAIL rand_timing txn %0d bus %0d: count %0d rsp %0d ready %0d, required 1 %0d %0d",
                    i, sel, rc, rn, yn, s + d + 1, s + d + b + 1);
            end
            if (wr) begin
                ref_mem[ad] = wd;
                checks++;
                if (o_rdata !== last_rd[sel]) begin
                    errors++; $display("[TB] FAIL rand_rdata_hold txn %0d: got %h, required %h", i, o_rdata, last_rd[sel]);
                end
            end else begin
                checks++;
                if (rd !== ref_mem[ad]) begin
                    errors++; $display("[TB] FAIL rand_read txn %0d addr %0d: got %h, required %h", i, ad, rd, ref_mem[ad]);
                end
                last_rd[sel] = ref_mem[ad];
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        $display("[TB] fsmc_master bench start");
        test_reset();
        test_write_timing();
        test_read_capture();
        test_back_to_back();
        test_clamped_timing();
        test_reset_mid_data();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsmc_master.md
Name: fsmc_master

Overview:
- Initiator end of the 5-bit-address / 8-bit-data FSMC asynchronous SRAM-style bus that the motor CPLD serves as responder: drives A, NE1, NOE, NWE and D with programmable setup/strobe/turnaround timing.
- Used as the STM32-side bus model on the bench-test board and as the bridge master when a second CPLD reads or writes the motor register file (registers 0-13 control/PWM, 15-18 status).
- Accepts single read/write requests via valid/ready and returns one response per request.

Parameters:
- ADDSET, 2, SETUP-phase cycles: NE1 low and A valid before the strobe (1-15; 0 is treated as 1).
- DATAST, 4, DATA-phase cycles with the NOE/NWE strobe low (2-15; values below 2 are treated as 2, because the responder samples on the falling clock edge).
- BUSTURN, 2, TURN-phase cycles with NE1 high before the next access (1-15; 0 is treated as 1).

Ports:
- CLK        in   1  system clock, 50 MHz
- RST_N      in   1  asynchronous active-low reset
- REQ_VALID  in   1  request present
- REQ_READY  out  1  high only in IDLE
- REQ_WR     in   1  1 = write, 0 = read
- REQ_ADDR   in   5  register address
- REQ_WDATA  in   8  write data
- RSP_VALID  out  1  one-cycle completion pulse (reads and writes)
- RSP_RDATA  out  8  read data, held until the next read completes
- BUSY       out  1  state is not IDLE
- FSMC_A     out  5  bus address
- FSMC_NE1   out  1  chip enable, active low
- FSMC_NOE   out  1  output enable, active low
- FSMC_NWE   out  1  write enable, active low
- FSMC_D_O   out  8  data driven to the bus
- FSMC_D_OE  out  1  pad tristate enable; the pad lives at top level
- FSMC_D_I   in   8  data sampled from the bus

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - state = IDLE.
  - FSMC_NE1 = FSMC_NOE = FSMC_NWE = 1.
  - FSMC_D_OE = 0, FSMC_A = 0, FSMC_D_O = 0.
  - RSP_VALID = 0, RSP_RDATA = 0, BUSY = 0, REQ_READY = 1 after release.
  - Any in-flight transaction is dropped with no response.
- All outputs are registered; there are no combinational paths from inputs to bus pins.
- States: IDLE -> SETUP -> DATA -> TURN -> IDLE. A 4-bit down-counter is loaded on each state entry.
- IDLE:
  - REQ_READY = 1.
  - On REQ_VALID & REQ_READY at rising edge k: latch REQ_WR/ADDR/WDATA and enter SETUP.
  - REQ_VALID is ignored in all other states.
- SETUP (ADDSET cycles, starting after edge k):
  - NE1 = 0, A = latched addr, NOE = NWE = 1.
  - For writes, D_OE = 1 and D_O = wdata; for reads, D_OE = 0.
- DATA (DATAST cycles):
  - A and NE1 held.
  - Write: NWE = 0, D_OE = 1. Read: NOE = 0, D_OE = 0.
  - Read data: FSMC_D_I is captured into RSP_RDATA on the rising edge that exits DATA, i.e. after the strobe has been low for DATAST full cycles.
- TURN (BUSTURN cycles):
  - NE1 = NOE = NWE = 1; A held.
  - For writes, D_OE stays 1 through the first TURN cycle (data hold), then 0.
  - RSP_VALID = 1 during the first TURN cycle only.
  - On counter expiry, go to IDLE.
- Timing:
  - Request to RSP_VALID latency = ADDSET + DATAST + 1 cycles.
  - Request to next REQ_READY = ADDSET + DATAST + BUSTURN + 1 cycles.
  - Defaults give 7 and 9 cycles.
- Strobes never overlap: NOE and NWE are never both 0. D_OE = 1 while NOE = 0 is forbidden.
- Back-to-back requests: REQ_VALID held high with new data is accepted on the first IDLE cycle. NE1 is high for at least BUSTURN + 1 cycles between accesses.
- Address changes only in IDLE → SETUP; it is stable for the full NE1-low window.

Decomposition:
- Shared package fsmc_pkg holds:
  - FSMC_AW = 5, FSMC_DW = 8.
  - State enum {IDLE, SETUP, DATA, TURN}.
  - Register-map constants REG_CTRL12 = 0, REG_M1_CNT_L = 1 … REG_M3_DUTY_H = 13, REG_S_STAT = 15, REG_M1_STAT = 16, REG_M2_STAT = 17, REG_M3_STAT = 18.
  - Timing-clamp function.
- No sub-module; the phase counter stays inline. The D tristate buffer is instantiated at top level.

Test Plan:
- Write 0xA5 to addr 3 with defaults:
  - NE1 low for exactly 6 cycles; NWE low for 4 cycles, starting 2 cycles after NE1 falls.
  - A = 3 and D_O = 0xA5 stable throughout; D_OE drops 1 cycle after NWE rises.
  - RSP_VALID at request + 7; REQ_READY returns at + 9.
- Read addr 16 with FSMC_D_I = 0x5A driven only during the last DATA cycle:
  - RSP_RDATA = 0x5A; RSP_VALID pulses once; D_OE stays 0 throughout.
- Against the Electric_bend responder model:
  - Write 0x34 to addr 3, then 0x12 to addr 4, then read both back → 0x34 and 0x12.
  - REQ_VALID held continuously: NE1 high ≥ 3 cycles between the accesses.
- Parameters ADDSET = 0, DATAST = 1, BUSTURN = 0:
  - Clamped to 1/2/1; NWE low for 2 cycles; next REQ_READY at + 5.
- Assert RST_N low mid-DATA of a write:
  - Same cycle: NE1 = NWE = 1, D_OE = 0, BUSY = 0; no RSP_VALID.
  - After release, a read of addr 0 completes normally.
- Random 500 mixed read/write requests with random REQ_VALID gaps:
  - Assertions hold: never NOE = NWE = 0 together; never D_OE = 1 with NOE = 0.
  - Exactly one RSP_VALID per accepted request.
